// File: rtl/andrewm_uart_to_parallel_pkg.sv
// Shared definitions for the UART receiver (and its transmitter partner):
// FSM state encoding, default baud divisor and 8N1 frame constants.
package andrewm_uart_to_parallel_pkg;

    // Same default divisor as the parallel-to-UART transmitter's baud counter.
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 256;

    // 8N1 frame: eight data bits, LSB first, one stop bit at line-idle level.
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_e;

endpackage

// File: rtl/andrewm_sync2.sv
// Two-flop synchronizer for the asynchronous rx line.
// Ports: clk, reset (sync, active-high), d_i (async input), q_o (synchronized).
// Both stages reset to 1 so the line reads as idle while in reset.
module andrewm_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/andrewm_uart_to_parallel.sv
// UART 8N1 receiver: deserialises frames from rx into a held byte that is
// read out as two nibbles, with valid/ack handshake and error flags.
// Ports: clk, reset (sync, active-high), rx (async serial, idle high),
//        nibble_sel (0 = low nibble, 1 = high nibble), ack (byte consumed),
//        nibble (selected nibble, combinational), valid (unread byte held),
//        frame_err (last frame had a bad stop bit), overrun (sticky),
//        busy (receiver not idle).
module andrewm_uart_to_parallel
    import andrewm_uart_to_parallel_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       nibble_sel,
    input  logic       ack,
    output logic [3:0] nibble,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic                 rx_s;
    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic [1:0]           fill_q,    fill_d;

    andrewm_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            fill_q    <= fill_d;
        end
    end

    // Next-state, bit timing, sampling and handshake flags.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        // Tracks synchronizer fill after reset: its reset value of 1 is not a
        // real observation of the line, so it must not release WAIT_IDLE.
        fill_d    = {fill_q[0], 1'b1};

        if (ack && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (fill_q[1] && rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    // A line already back high at mid start bit was a glitch.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (rx_s == STOP_LEVEL) begin
                        // A same-cycle ack frees the slot, so the new byte is not an overrun.
                        if (valid_q && !ack) begin
                            ovr_d = 1'b1;
                        end
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    assign nibble    = nibble_sel ? data_q[7:4] : data_q[3:0];
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_andrewm_uart_to_parallel.sv
// Self-checking bench for andrewm_uart_to_parallel with CLKS_PER_BIT = 16.
module tb_andrewm_uart_to_parallel;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       nibble_sel;
    logic       ack;
    logic [3:0] nibble;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model of the receiver's visible state.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       m_ovr;

    andrewm_uart_to_parallel #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .nibble_sel (nibble_sel),
        .ack        (ack),
        .nibble     (nibble),
        .valid      (valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 2000000)", $time);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_now);
        if (stop_ok) begin
            if (m_valid && !ack_now) m_ovr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
            m_ferr  = 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    // Drives one frame starting at the current time; returns 10 bit times later.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b ferr=%b ovr=%b, required 0 0 0", valid, frame_err, overrun);
        end
        nibble_sel = 1'b0; #1;
        checks++;
        if (nibble !== 4'h0) begin
            errors++;
            $display("FAIL reset_nibble: got %h, required 0", nibble);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 1 (waiting for idle)", busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int k = 1; k <= LAT + 10 && lat < 0; k++) begin
                    @(negedge clk);
                    if (valid === 1'b1) lat = k;
                end
            end
        join
        model_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required %0d +/- 2", lat, LAT);
        end
        nibble_sel = 1'b0; #1;
        checks++;
        if (nibble !== m_data[3:0]) begin
            errors++;
            $display("FAIL basic_lo: got %h, required %h", nibble, m_data[3:0]);
        end
        nibble_sel = 1'b1; #1;
        checks++;
        if (nibble !== m_data[7:4]) begin
            errors++;
            $display("FAIL basic_hi: got %h, required %h", nibble, m_data[7:4]);
        end
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_flags: ferr=%b busy=%b valid=%b, required 0 0 1", frame_err, busy, valid);
        end
        @(negedge clk);
        pulse_ack();
        @(negedge clk);
        checks++;
        if (valid !== m_valid) begin
            errors++;
            $display("FAIL basic_ack: valid=%b, required %b", valid, m_valid);
        end
    endtask

    task automatic test_glitch();
        int rose = 0;
        int fell = 0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        for (int k = 0; k < 6 && !rose; k++) begin
            if (busy === 1'b1) rose = 1;
            else @(negedge clk);
        end
        checks++;
        if (!rose) begin
            errors++;
            $display("FAIL glitch_busy_rise: busy=%b, required 1", busy);
        end
        for (int k = 0; k < HALF + 6 && !fell; k++) begin
            @(negedge clk);
            if (busy === 1'b0) fell = 1;
        end
        checks++;
        if (!fell) begin
            errors++;
            $display("FAIL glitch_busy_fall: busy=%b, required 0", busy);
        end
        repeat (CPB * 10) @(negedge clk);
        checks++;
        if (valid !== m_valid || frame_err !== m_ferr || overrun !== m_ovr) begin
            errors++;
            $display("FAIL glitch_flags: valid=%b ferr=%b ovr=%b, required %b %b %b",
                     valid, frame_err, overrun, m_valid, m_ferr, m_ovr);
        end
    endtask

    task automatic test_frame_err();
        int idle = 0;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++;
        if (frame_err !== m_ferr || valid !== m_valid) begin
            errors++;
            $display("FAIL ferr_flags: ferr=%b valid=%b, required %b %b", frame_err, valid, m_ferr, m_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_busy_low: busy=%b, required 1", busy);
        end
        nibble_sel = 1'b0; #1;
        checks++;
        if (nibble !== m_data[3:0]) begin
            errors++;
            $display("FAIL ferr_data_kept: got %h, required %h", nibble, m_data[3:0]);
        end
        @(negedge clk);
        rx = 1'b1;
        for (int k = 0; k < 8 && !idle; k++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL ferr_recover: busy=%b, required 0", busy);
        end
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        nibble_sel = 1'b1; #1;
        checks++;
        if (frame_err !== 1'b0 || valid !== 1'b1 || nibble !== m_data[7:4]) begin
            errors++;
            $display("FAIL ferr_good: ferr=%b valid=%b hi=%h, required 0 1 %h",
                     frame_err, valid, nibble, m_data[7:4]);
        end
        @(negedge clk);
        pulse_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        checks++;
        if (overrun !== m_ovr || valid !== m_valid) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b valid=%b, required %b %b", overrun, valid, m_ovr, m_valid);
        end
        for (int s = 0; s < 2; s++) begin
            nibble_sel = s[0]; #1;
            checks++;
            if (nibble !== (s[0] ? m_data[7:4] : m_data[3:0])) begin
                errors++;
                $display("FAIL ovr_nibble sel=%0d: got %h, required 2", s, nibble);
            end
        end
        @(negedge clk);
        pulse_ack();
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: valid=%b ovr=%b, required 0 1", valid, overrun);
        end
    endtask

    task automatic test_back_to_back_ack();
        apply_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_reset_clear: ovr=%b, required 0", overrun);
        end
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        // Second frame completes LAT cycles after its start; ack lands on that edge.
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        model_frame(8'h77, 1'b1, 1'b1);
        checks++;
        if (valid !== m_valid || overrun !== m_ovr) begin
            errors++;
            $display("FAIL ackcol_flags: valid=%b ovr=%b, required %b %b", valid, overrun, m_valid, m_ovr);
        end
        for (int s = 0; s < 2; s++) begin
            nibble_sel = s[0]; #1;
            checks++;
            if (nibble !== 4'h7) begin
                errors++;
                $display("FAIL ackcol_nibble sel=%0d: got %h, required 7", s, nibble);
            end
        end
        @(negedge clk);
        pulse_ack();
    endtask

    task automatic test_reset_midframe();
        int idle = 0;
        int bad = 0;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + HALF) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rx    = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_hold: %0d cycles left WAIT_IDLE or showed valid, required 0", bad);
        end
        rx = 1'b1;
        for (int k = 0; k < 8 && !idle; k++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL midrst_idle: busy=%b, required 0", busy);
        end
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b0);
        nibble_sel = 1'b0; #1;
        checks++;
        if (valid !== 1'b1 || nibble !== m_data[3:0] || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: valid=%b lo=%h ferr=%b, required 1 %h 0",
                     valid, nibble, frame_err, m_data[3:0]);
        end
        @(negedge clk);
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       good;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            model_frame(b, good, 1'b0);
            rx = 1'b1;
            repeat (good ? 2 : 6) @(negedge clk);
            nibble_sel = 1'($urandom_range(0, 1)); #1;
            checks++;
            if (valid !== m_valid || frame_err !== m_ferr || overrun !== m_ovr ||
                nibble !== (nibble_sel ? m_data[7:4] : m_data[3:0])) begin
                errors++;
                $display("FAIL rand_%0d: v=%b fe=%b ov=%b nib=%h, required %b %b %b %h",
                         n, valid, frame_err, overrun, nibble, m_valid, m_ferr, m_ovr,
                         nibble_sel ? m_data[7:4] : m_data[3:0]);
            end
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end
    endtask

    initial begin
        reset      = 1'b1;
        rx         = 1'b1;
        nibble_sel = 1'b0;
        ack        = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back_ack();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
